// File: rtl/curve_lut_loader.sv
// curve_lut_loader: streams DEPTH curve entries into the LUT write port and flags a complete table.
// Define CURVE_LUT_LOADER_CHECKSUM_EN to require a trailing checksum word before lut_valid.
module curve_lut_loader #(
  parameter int DEPTH  = 255,
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              mem_wen,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [AWIDTH:0]   load_count,
  output logic              lut_valid,
  output logic              busy,
  output logic              err
);
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE, CHECK} state_t;
  localparam state_t FINAL = CHECK;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam state_t FINAL = DONE;
`endif
  state_t state_q, state_d;
  logic wen_q, wen_d, valid_q, valid_d, accept, last;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [AWIDTH:0] cnt_q, cnt_d;
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;
  logic err_q, err_d;
  assign in_ready = state_q == LOAD || state_q == CHECK;
  assign err = err_q;
`else
  assign in_ready = state_q == LOAD;
  assign err = 1'b0;
`endif
  assign accept = in_valid && in_ready;
  assign last = cnt_q == (AWIDTH+1)'(DEPTH - 1);
  assign busy = in_ready;
  assign mem_wen = wen_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign load_count = cnt_q;
  assign lut_valid = valid_q;
  always_comb begin
    state_d = state_q;
    wen_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    valid_d = state_q == DONE && !start;
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
    sum_d = sum_q;
    err_d = err_q;
`endif
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = LOAD;
      cnt_d = '0;
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
      sum_d = '0;
      err_d = 1'b0;
`endif
    end
    if (state_q == LOAD && accept) begin
      wen_d = 1'b1;
      waddr_d = cnt_q[AWIDTH-1:0];
      wdata_d = in_data;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? FINAL : LOAD;
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
      sum_d = sum_q + in_data;
`endif
    end
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
    // the checksum word is consumed here and never written to memory
    if (state_q == CHECK && accept) begin
      state_d = in_data == sum_q ? DONE : IDLE;
      err_d = in_data != sum_q;
    end
`endif
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
      sum_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
`ifdef CURVE_LUT_LOADER_CHECKSUM_EN
      sum_q <= sum_d;
      err_q <= err_d;
`endif
    end
  end
endmodule
